button_conditioner: RTL and testbench

- Conditions the raw DE0 push-button pins before they reach the Nios system's 3-bit button PIO input.
- Per channel, it synchronises the pin, debounces it, and normalises it so that 1 means pressed.
- It also produces single-cycle press and release strobes for the PLL/divider control logic.
- It sits between the board pins and the system's button input, in the same clock domain as the system reference clock.

---
 rtl/button_conditioner.sv | 76 +++++++
 tb/tb_button_conditioner.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Push-button front end: per-channel 2-FF sync, debounce, polarity fix,
// plus one-cycle press/release strobes. Ports: clk, reset, button_raw in; button_level/press/release out.
module button_conditioner #(
  parameter int NUM_INPUTS      = 3,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_INPUTS-1:0] button_raw,
  output logic [NUM_INPUTS-1:0] button_level,
  output logic [NUM_INPUTS-1:0] button_press,
  output logic [NUM_INPUTS-1:0] button_release
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [NUM_INPUTS-1:0] REL =
    {NUM_INPUTS{ACTIVE_LOW != 0}};

  logic [NUM_INPUTS-1:0]         sync1_q, sync1_d;
  logic [NUM_INPUTS-1:0]         sync2_q, sync2_d;
  logic [NUM_INPUTS-1:0][CW-1:0] cnt_q, cnt_d;
  logic [NUM_INPUTS-1:0]         level_q, level_d;
  logic [NUM_INPUTS-1:0]         press_q, press_d;
  logic [NUM_INPUTS-1:0]         release_q, release_d;
  logic [NUM_INPUTS-1:0]         s;

  // normalised sample: 1 = pressed
  assign s = sync2_q ^ REL;

  always_comb begin
    sync1_d   = button_raw;
    sync2_d   = sync1_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (s[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        // held long enough: accept and restart the count
        cnt_d[i]     = '0;
        level_d[i]   = s[i];
        press_d[i]   = s[i];
        release_d[i] = ~s[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= REL;
      sync2_q   <= REL;
      cnt_q     <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign button_level   = level_q;
  assign button_press   = press_q;
  assign button_release = release_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: window model of the debounce rule
// plus directed edge-exact literal checks.
module tb_button_conditioner;

  localparam int N = 3;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] button_raw;
  logic [N-1:0] button_level;
  logic [N-1:0] button_press;
  logic [N-1:0] button_release;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  button_conditioner #(
    .NUM_INPUTS(N),
    .DEBOUNCE_CYCLES(D),
    .ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .button_raw(button_raw),
    .button_level(button_level),
    .button_press(button_press),
    .button_release(button_release)
  );

  always #5 clk = ~clk;

  // Model: pressed-sample at edge n is the inverted pin seen two edges
  // earlier (released before that since reset). Level flips when the
  // last D samples since reset all disagree with it.
  int ns = 0;
  bit rh[N][4096];
  bit sh[N][4096];
  bit ok;
  logic [N-1:0] m_lvl = '0;
  logic [N-1:0] m_prs = '0;
  logic [N-1:0] m_rel = '0;

  always @(posedge clk) begin
    if (reset) begin
      ns = 0;
      m_lvl = '0;
      m_prs = '0;
      m_rel = '0;
    end else begin
      ns++;
      m_prs = '0;
      m_rel = '0;
      for (int c = 0; c < N; c++) begin
        rh[c][ns] = button_raw[c];
        sh[c][ns] = (ns >= 3) ? ~rh[c][ns-2] : 1'b0;
        ok = (ns >= D);
        for (int j = 0; j < D; j++)
          if (ok && sh[c][ns-j] == m_lvl[c]) ok = 1'b0;
        if (ok) begin
          m_lvl[c] = ~m_lvl[c];
          m_prs[c] = m_lvl[c];
          m_rel[c] = ~m_lvl[c];
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [N-1:0] act,
                     input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_level", button_level, m_lvl);
      chk("model_press", button_press, m_prs);
      chk("model_release", button_release, m_rel);
    end
  end

  task automatic wait_cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic quiet(input string nm, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk(nm, button_level | button_press | button_release, '0);
    end
  endtask

  // Edge 1 is the first edge sampling the new pin value.
  task automatic walk(input string nm, input logic [N-1:0] lvl9,
                      input logic [N-1:0] lvl10,
                      input logic [N-1:0] p10,
                      input logic [N-1:0] r10);
    for (int e = 1; e <= 11; e++) begin
      @(negedge clk);
      if (e == 9) chk({nm, "_lvl_e9"}, button_level, lvl9);
      if (e == 10) begin
        chk({nm, "_lvl_e10"}, button_level, lvl10);
        chk({nm, "_prs_e10"}, button_press, p10);
        chk({nm, "_rel_e10"}, button_release, r10);
      end
      if (e == 11) begin
        chk({nm, "_prs_e11"}, button_press, '0);
        chk({nm, "_rel_e11"}, button_release, '0);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    button_raw = 3'b111;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    chk("reset_level", button_level, '0);
    chk("reset_strobes", button_press | button_release, '0);
    quiet("idle", 4);

    // clean press, channel 0
    button_raw[0] = 1'b0;
    walk("press0", 3'b000, 3'b001, 3'b001, 3'b000);
    button_raw[0] = 1'b1;
    wait_cyc(12);

    // bounce on channel 1: 13 toggles, 3 cycles apart, ends low
    for (int t = 0; t < 13; t++) begin
      button_raw[1] = ~button_raw[1];
      if (t < 12) quiet("bounce", 3);
    end
    walk("bounce1", 3'b000, 3'b010, 3'b010, 3'b000);
    button_raw[1] = 1'b1;
    wait_cyc(12);

    // release on channel 2
    button_raw[2] = 1'b0;
    wait_cyc(12);
    button_raw[2] = 1'b1;
    walk("rel2", 3'b100, 3'b000, 3'b000, 3'b100);
    wait_cyc(2);

    // near miss: 7 cycles low
    button_raw[0] = 1'b0;
    wait_cyc(7);
    button_raw[0] = 1'b1;
    quiet("nearmiss", 15);

    // just long enough: 8 cycles low is accepted
    button_raw[0] = 1'b0;
    wait_cyc(8);
    button_raw[0] = 1'b1;
    @(negedge clk);
    chk("exact8_lvl_e9", button_level, 3'b000);
    @(negedge clk);
    chk("exact8_prs_e10", button_press, 3'b001);
    wait_cyc(20);
    chk("exact8_after", button_level, 3'b000);

    // reset mid-debounce, channel 2 already pressed
    button_raw[2] = 1'b0;
    wait_cyc(12);
    chk("pre_rst_lvl", button_level, 3'b100);
    button_raw[0] = 1'b0;
    wait_cyc(5);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_lvl", button_level, 3'b000);
    chk("rst_strobes", button_press | button_release, 3'b000);
    reset = 1'b0;
    walk("rst", 3'b000, 3'b101, 3'b101, 3'b000);
    button_raw = 3'b111;
    wait_cyc(14);

    // all channels on the same edge
    button_raw = 3'b000;
    walk("sim", 3'b000, 3'b111, 3'b111, 3'b000);
    button_raw = 3'b111;
    walk("simrel", 3'b111, 3'b000, 3'b000, 3'b111);
    wait_cyc(3);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
